// File: rtl/wave_table_pkg.sv
// Shared types and helpers for the multi-channel waveform lookup table.
// The negate helper works on a wide signed value so any sample width up to MAX_DATA_SIZE can use it.
package wave_table_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  localparam int unsigned MAX_DATA_SIZE = 64;

  // Two's-complement negate of a width-bit value held sign-extended in x.
  // The most negative code has no positive counterpart, so it maps to the most positive one.
  function automatic logic signed [MAX_DATA_SIZE-1:0] sat_neg(
    input logic signed [MAX_DATA_SIZE-1:0] x,
    input int unsigned                     width
  );
    logic signed [MAX_DATA_SIZE-1:0] min_val;
    min_val = {MAX_DATA_SIZE{1'b1}} << (width - 1);
    if (x == min_val) return ~min_val;
    return -x;
  endfunction

endpackage

// File: rtl/wave_table_fold.sv
// Second read stage for one channel: applies the quadrant sign with saturation and
// registers the sample, holding the previous sample while no request is in flight.
module wave_table_fold
  import wave_table_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_res,
  input  logic                 s1_valid,
  input  logic                 s1_neg,
  input  logic [DATA_SIZE-1:0] s1_data,
  output logic                 valid,
  output logic [DATA_SIZE-1:0] data
);

  logic [DATA_SIZE-1:0] folded;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    folded = s1_data;
    if (s1_neg) begin
      folded = DATA_SIZE'(sat_neg(MAX_DATA_SIZE'(signed'(s1_data)), DATA_SIZE));
    end
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= s1_valid;
      if (s1_valid) data <= folded;
    end
  end

endmodule

// File: rtl/wave_table.sv
// Run-time loadable signed waveform table with NUM_CH independent two-stage read channels.
// Optional quarter-wave storage rebuilds the full period by mirroring the index and negating.
module wave_table
  import wave_table_pkg::*;
#(
  parameter int ADDRESS_SIZE = 8,
  parameter int DATA_SIZE    = 8,
  parameter int NUM_CH       = 2,
  parameter int QUARTER      = 0
) (
  input  logic                           i_clk,
  input  logic                           i_res,
  output logic                           o_ready,
  input  logic                           i_wr_en,
  input  logic [ADDRESS_SIZE-1:0]        i_wr_addr,
  input  logic [DATA_SIZE-1:0]           i_wr_data,
  input  logic [NUM_CH-1:0]              i_rd_valid,
  input  logic [NUM_CH*ADDRESS_SIZE-1:0] i_rd_addr,
  output logic [NUM_CH-1:0]              o_valid,
  output logic [NUM_CH*DATA_SIZE-1:0]    o_data
);

  localparam int IDX_W = (QUARTER != 0) ? ADDRESS_SIZE - 2 : ADDRESS_SIZE;
  localparam int DEPTH = 1 << IDX_W;

  state_t               state;
  logic [IDX_W-1:0]     clr_cnt;
  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic                 wr_fire;
  logic [IDX_W-1:0]     wr_idx;
  logic [DATA_SIZE-1:0] wr_val;
  logic                 unused_wr_addr;

  // In quarter mode the quadrant bits of the write address carry no information.
  assign unused_wr_addr = ^i_wr_addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      state   <= INIT;
      clr_cnt <= '0;
      o_ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state   <= RUN;
            o_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN:     o_ready <= 1'b1;
        default: state   <= INIT;
      endcase
    end
  end

  // The single write port is shared: the clear sweep owns it during INIT, the user during RUN.
  always_comb begin
    wr_fire = 1'b0;
    wr_idx  = '0;
    wr_val  = '0;
    if (state == INIT) begin
      wr_fire = 1'b1;
      wr_idx  = clr_cnt;
    end else begin
      wr_fire = i_wr_en;
      wr_idx  = i_wr_addr[IDX_W-1:0];
      wr_val  = i_wr_data;
    end
  end

  // NOTE: the table array has no reset; the INIT sweep clears it instead of a reset on every entry.
  always_ff @(posedge i_clk) begin
    if (wr_fire) mem[wr_idx] <= wr_val;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ADDRESS_SIZE-1:0] ch_addr;
    logic [IDX_W-1:0]        ch_idx;
    logic                    ch_neg;
    logic                    rd_en;
    logic                    s1_valid;
    logic                    s1_neg;
    logic [DATA_SIZE-1:0]    s1_data;

    assign ch_addr = i_rd_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
    assign rd_en   = i_rd_valid[k] && (state == RUN);

    if (QUARTER != 0) begin : g_quarter
      quadrant_t quad;
      assign quad   = quadrant_t'(ch_addr[ADDRESS_SIZE-1 -: 2]);
      assign ch_idx = (quad == Q1 || quad == Q3) ? ~ch_addr[IDX_W-1:0] : ch_addr[IDX_W-1:0];
      assign ch_neg = (quad == Q2 || quad == Q3);
    end else begin : g_full
      assign ch_idx = ch_addr;
      assign ch_neg = 1'b0;
    end

    // The tap samples the table before this edge's write lands, so same-cycle reads see old data.
    always_ff @(posedge i_clk or negedge i_res) begin
      if (!i_res) begin
        s1_valid <= 1'b0;
        s1_neg   <= 1'b0;
        s1_data  <= '0;
      end else begin
        s1_valid <= rd_en;
        if (rd_en) begin
          s1_neg  <= ch_neg;
          s1_data <= mem[ch_idx];
        end
      end
    end

    wave_table_fold #(
      .DATA_SIZE(DATA_SIZE)
    ) u_fold (
      .i_clk   (i_clk),
      .i_res   (i_res),
      .s1_valid(s1_valid),
      .s1_neg  (s1_neg),
      .s1_data (s1_data),
      .valid   (o_valid[k]),
      .data    (o_data[k*DATA_SIZE +: DATA_SIZE])
    );
  end

endmodule
